// File: rtl/bus_endpoint_if.sv
// FU-side and link-side signal bundle for bus_endpoint.
// slave is the endpoint view; master is the FU/link environment view.
interface bus_endpoint_if #(
  parameter int ADDR_W = 4,
  parameter int TAG_W  = 4,
  parameter int MSG_W  = 64
);
  logic              fu_val_i;
  logic [ADDR_W-1:0] fu_dst_i;
  logic [TAG_W-1:0]  fu_tag_i;
  logic [MSG_W-1:0]  fu_msg_i;
  logic              fu_ack_o;
  logic              fu_val_o;
  logic [ADDR_W-1:0] fu_src_o;
  logic [TAG_W-1:0]  fu_tag_o;
  logic [MSG_W-1:0]  fu_msg_o;
  logic              fu_rdy_i;
  logic              net_tx_valid_o;
  logic              net_tx_ready_i;
  logic [ADDR_W-1:0] net_tx_src_o;
  logic [ADDR_W-1:0] net_tx_dst_o;
  logic [TAG_W-1:0]  net_tx_tag_o;
  logic [MSG_W-1:0]  net_tx_msg_o;
  logic              net_rx_valid_i;
  logic              net_rx_ready_o;
  logic [ADDR_W-1:0] net_rx_src_i;
  logic [ADDR_W-1:0] net_rx_dst_i;
  logic [TAG_W-1:0]  net_rx_tag_i;
  logic [MSG_W-1:0]  net_rx_msg_i;
  logic [15:0]       drop_cnt_o;

  modport slave (
    input  fu_val_i, fu_dst_i, fu_tag_i, fu_msg_i,
    output fu_ack_o,
    output fu_val_o, fu_src_o, fu_tag_o, fu_msg_o,
    input  fu_rdy_i,
    output net_tx_valid_o,
    input  net_tx_ready_i,
    output net_tx_src_o, net_tx_dst_o,
    output net_tx_tag_o, net_tx_msg_o,
    input  net_rx_valid_i,
    output net_rx_ready_o,
    input  net_rx_src_i, net_rx_dst_i,
    input  net_rx_tag_i, net_rx_msg_i,
    output drop_cnt_o
  );

  modport master (
    output fu_val_i, fu_dst_i, fu_tag_i, fu_msg_i,
    input  fu_ack_o,
    input  fu_val_o, fu_src_o, fu_tag_o, fu_msg_o,
    output fu_rdy_i,
    input  net_tx_valid_o,
    output net_tx_ready_i,
    input  net_tx_src_o, net_tx_dst_o,
    input  net_tx_tag_o, net_tx_msg_o,
    output net_rx_valid_i,
    input  net_rx_ready_o,
    output net_rx_src_i, net_rx_dst_i,
    output net_rx_tag_i, net_rx_msg_i,
    input  drop_cnt_o
  );
endinterface

// File: rtl/bus_endpoint.sv
// Network endpoint: FU sends go out through a TX FIFO stamped with NODE_ID,
// inbound packets addressed here queue in an RX FIFO, others are counted.
module bus_endpoint #(
  parameter int NODE_ID  = 0,
  parameter int ADDR_W   = 4,
  parameter int TAG_W    = 4,
  parameter int MSG_W    = 64,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  bus_endpoint_if.slave bus
);
  localparam int TXA = $clog2(TX_DEPTH);
  localparam int RXA = $clog2(RX_DEPTH);
  localparam logic [ADDR_W-1:0] NODE = ADDR_W'(NODE_ID);
  localparam logic [TXA:0] TX_MAX = (TXA+1)'(TX_DEPTH);
  localparam logic [RXA:0] RX_MAX = (RXA+1)'(RX_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] dst;
    logic [TAG_W-1:0]  tag;
    logic [MSG_W-1:0]  msg;
  } tx_ent_t;

  typedef struct packed {
    logic [ADDR_W-1:0] src;
    logic [TAG_W-1:0]  tag;
    logic [MSG_W-1:0]  msg;
  } rx_ent_t;

  tx_ent_t        tx_mem [TX_DEPTH];
  logic [TXA-1:0] tx_wp;
  logic [TXA-1:0] tx_rp;
  logic [TXA:0]   tx_cnt;
  logic           tx_push;
  logic           tx_pop;
  logic           tx_full;
  logic           tx_empty;

  rx_ent_t        rx_mem [RX_DEPTH];
  logic [RXA-1:0] rx_wp;
  logic [RXA-1:0] rx_rp;
  logic [RXA:0]   rx_cnt;
  logic           rx_push;
  logic           rx_pop;
  logic           rx_full;
  logic           rx_empty;
  logic           rx_match;
  logic           rx_drop;
  logic [15:0]    drop_cnt;

  assign tx_full  = (tx_cnt == TX_MAX);
  assign tx_empty = (tx_cnt == '0);
  assign tx_pop   = !tx_empty && bus.net_tx_ready_i;
  // gated by reset so no ack can escape while the FIFO is being cleared
  assign tx_push  = rst_n && bus.fu_val_i && (!tx_full || tx_pop);

  assign bus.fu_ack_o       = tx_push;
  assign bus.net_tx_valid_o = !tx_empty;
  assign bus.net_tx_src_o   = NODE;
  assign bus.net_tx_dst_o   = tx_mem[tx_rp].dst;
  assign bus.net_tx_tag_o   = tx_mem[tx_rp].tag;
  assign bus.net_tx_msg_o   = tx_mem[tx_rp].msg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TX_DEPTH; i++)
        tx_mem[i] <= '0;
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wp] <= '{
          dst: bus.fu_dst_i,
          tag: bus.fu_tag_i,
          msg: bus.fu_msg_i
        };
        tx_wp <= tx_wp + 1'b1;
      end
      if (tx_pop)
        tx_rp <= tx_rp + 1'b1;
      unique case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  assign rx_full  = (rx_cnt == RX_MAX);
  assign rx_empty = (rx_cnt == '0);
  assign rx_match = (bus.net_rx_dst_i == NODE);
  assign rx_pop   = !rx_empty && bus.fu_rdy_i;
  assign rx_push  = bus.net_rx_valid_i && rx_match
                 && (!rx_full || rx_pop);
  assign rx_drop  = bus.net_rx_valid_i && !rx_match;

  // misaddressed traffic is always sunk so it never backs up the link
  assign bus.net_rx_ready_o = !rx_match || !rx_full || rx_pop;
  assign bus.fu_val_o       = !rx_empty;
  assign bus.fu_src_o       = rx_mem[rx_rp].src;
  assign bus.fu_tag_o       = rx_mem[rx_rp].tag;
  assign bus.fu_msg_o       = rx_mem[rx_rp].msg;
  assign bus.drop_cnt_o     = drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RX_DEPTH; i++)
        rx_mem[i] <= '0;
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wp] <= '{
          src: bus.net_rx_src_i,
          tag: bus.net_rx_tag_i,
          msg: bus.net_rx_msg_i
        };
        rx_wp <= rx_wp + 1'b1;
      end
      if (rx_pop)
        rx_rp <= rx_rp + 1'b1;
      unique case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
      if (rx_drop && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 1'b1;
    end
  end
endmodule
